// File: rtl/output_vc_buffer_if.sv
// rtl/output_vc_buffer_if.sv - port bundle between an output-port controller and its arbiter/link side
interface output_vc_buffer_if #(
  parameter int DW    = 64,
  parameter int NIN   = 5,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 polarity;
  logic [NIN-1:0]       grant;
  logic [NIN*DW-1:0]    data_in;
  logic                 receive_output;
  logic [DW-1:0]        data_out;
  logic                 send_output;
  logic                 accept;
  logic [NIN-1:0]       clear;
  logic [CW-1:0]        count_even;
  logic [CW-1:0]        count_odd;
  logic                 err_grant;

  modport master (
    output polarity, grant, data_in, receive_output,
    input  data_out, send_output, accept, clear, count_even, count_odd, err_grant
  );

  modport slave (
    input  polarity, grant, data_in, receive_output,
    output data_out, send_output, accept, clear, count_even, count_odd, err_grant
  );
endinterface

// File: rtl/output_vc_buffer.sv
// rtl/output_vc_buffer.sv - router output port with even/odd virtual-channel FIFOs
module output_vc_buffer #(
  parameter int DW    = 64,
  parameter int NIN   = 5,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output_vc_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_even [DEPTH];
  logic [DW-1:0] mem_odd  [DEPTH];

  logic [PW-1:0] wr_ptr_even, rd_ptr_even;
  logic [PW-1:0] wr_ptr_odd,  rd_ptr_odd;
  logic [CW-1:0] cnt_even, cnt_odd;
  logic          err_q;

  logic          grant_any, grant_legal;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          accept_c, push, pop;
  logic [DW-1:0] push_data, rd_head;

  // A one-hot grant is the only kind that may move data.
  assign grant_any   = |bus.grant;
  assign grant_legal = grant_any && ((bus.grant & (bus.grant - NIN'(1))) == '0);

  assign wr_cnt   = bus.polarity ? cnt_odd : cnt_even;
  assign rd_cnt   = bus.polarity ? cnt_even : cnt_odd;
  assign accept_c = (wr_cnt != CW'(DEPTH));
  assign push     = grant_legal && accept_c;
  assign pop      = bus.receive_output && (rd_cnt != '0);

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NIN; i++) begin
      push_data = push_data | (bus.data_in[i*DW +: DW] & {DW{bus.grant[i]}});
    end
  end

  assign rd_head = bus.polarity ? mem_even[rd_ptr_even] : mem_odd[rd_ptr_odd];

  assign bus.accept      = accept_c;
  assign bus.clear       = push ? bus.grant : '0;
  assign bus.send_output = pop;
  assign bus.data_out    = pop ? rd_head : '0;
  assign bus.count_even  = cnt_even;
  assign bus.count_odd   = cnt_odd;
  assign bus.err_grant   = err_q;

  // Storage is never reset; occupancy counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !bus.polarity) mem_even[wr_ptr_even] <= push_data;
    if (push &&  bus.polarity) mem_odd[wr_ptr_odd]   <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_even <= '0;
      rd_ptr_even <= '0;
      wr_ptr_odd  <= '0;
      rd_ptr_odd  <= '0;
      cnt_even    <= '0;
      cnt_odd     <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= grant_any && !grant_legal;
      // Push and pop always hit opposite VCs, so their count updates never collide.
      if (push) begin
        if (bus.polarity) begin
          wr_ptr_odd <= wr_ptr_odd + PW'(1);
          cnt_odd    <= cnt_odd + CW'(1);
        end else begin
          wr_ptr_even <= wr_ptr_even + PW'(1);
          cnt_even    <= cnt_even + CW'(1);
        end
      end
      if (pop) begin
        if (bus.polarity) begin
          rd_ptr_even <= rd_ptr_even + PW'(1);
          cnt_even    <= cnt_even - CW'(1);
        end else begin
          rd_ptr_odd <= rd_ptr_odd + PW'(1);
          cnt_odd    <= cnt_odd - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_output_vc_buffer.sv
// tb/tb_output_vc_buffer.sv - directed and randomized bench for output_vc_buffer against a queue model
module tb_output_vc_buffer;
  localparam int DW    = 64;
  localparam int NIN   = 5;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_vc_buffer_if #(.DW(DW), .NIN(NIN), .DEPTH(DEPTH)) bus ();

  output_vc_buffer #(.DW(DW), .NIN(NIN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] q_even[$];
  logic [DW-1:0] q_odd[$];
  logic          exp_err;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check the combinational view, advance the model, check registers.
  task automatic step(input logic pol, input logic [NIN-1:0] g, input int ch,
                      input logic [DW-1:0] val, input logic rx, input logic rst);
    int            wr_n, rd_n, ones;
    logic          exp_accept, exp_send, do_push;
    logic [DW-1:0] exp_dout, pushed;
    logic [NIN-1:0] exp_clear;
    bus.polarity       = pol;
    bus.grant          = g;
    for (int i = 0; i < NIN; i++) bus.data_in[i*DW +: DW] = {$urandom, $urandom};
    bus.data_in[ch*DW +: DW] = val;
    bus.receive_output = rx;
    reset              = rst;
    #3;
    wr_n = pol ? q_odd.size() : q_even.size();
    rd_n = pol ? q_even.size() : q_odd.size();
    ones = $countones(g);
    exp_accept = (wr_n < DEPTH);
    do_push    = (ones == 1) && exp_accept;
    exp_clear  = do_push ? g : '0;
    exp_send   = rx && (rd_n > 0);
    exp_dout   = '0;
    if (exp_send) exp_dout = pol ? q_even[0] : q_odd[0];
    pushed = '0;
    for (int i = 0; i < NIN; i++) if (g[i]) pushed = bus.data_in[i*DW +: DW];
    check("accept",      DW'(bus.accept),      DW'(exp_accept));
    check("clear",       DW'(bus.clear),       DW'(exp_clear));
    check("send_output", DW'(bus.send_output), DW'(exp_send));
    check("data_out",    bus.data_out,         exp_dout);
    @(posedge clk);
    if (rst) begin
      q_even.delete();
      q_odd.delete();
      exp_err = 1'b0;
    end else begin
      if (exp_send) begin
        if (pol) void'(q_even.pop_front()); else void'(q_odd.pop_front());
      end
      if (do_push) begin
        if (pol) q_odd.push_back(pushed); else q_even.push_back(pushed);
      end
      exp_err = (ones >= 2);
    end
    #1;
    check("count_even", DW'(bus.count_even), DW'(q_even.size()));
    check("count_odd",  DW'(bus.count_odd),  DW'(q_odd.size()));
    check("err_grant",  DW'(bus.err_grant),  DW'(exp_err));
  endtask

  initial begin
    logic [NIN-1:0] g;
    logic           pol;
    int             ch;
    reset              = 1'b1;
    bus.polarity       = 1'b0;
    bus.grant          = '0;
    bus.data_in        = '0;
    bus.receive_output = 1'b0;
    exp_err            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count_even", DW'(bus.count_even), '0);
    check("rst_count_odd",  DW'(bus.count_odd),  '0);
    check("rst_err_grant",  DW'(bus.err_grant),  '0);
    check("rst_accept",     DW'(bus.accept),     64'd1);

    // Single flit through the even VC with minimum latency.
    step(1'b0, 5'b00100, 2, 64'hA5, 1'b1, 1'b0);
    step(1'b1, 5'b00000, 0, 64'h0,  1'b1, 1'b0);
    check("a5_count_even", DW'(bus.count_even), '0);

    // Fill the even VC, then drain in FIFO order.
    step(1'b0, 5'b00001, 0, 64'd1, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 0, 64'd2, 1'b0, 1'b0);
    check("full_count_even", DW'(bus.count_even), 64'd2);
    step(1'b1, 5'b00000, 0, 64'd0, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 0, 64'd3, 1'b0, 1'b0);
    check("full_hold_count", DW'(bus.count_even), 64'd2);
    step(1'b1, 5'b00000, 0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 5'b00000, 0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 5'b00000, 0, 64'd0, 1'b1, 1'b0);

    // Pointer wrap through one VC.
    for (int v = 10; v <= 15; v++) begin
      step(1'b0, 5'b00010, 1, 64'(v), 1'b1, 1'b0);
      step(1'b1, 5'b00000, 0, 64'd0,  1'b1, 1'b0);
    end

    // Illegal grant: one-cycle error pulse, no push.
    step(1'b0, 5'b00110, 1, 64'hBAD, 1'b1, 1'b0);
    check("illegal_err", DW'(bus.err_grant), 64'd1);
    step(1'b1, 5'b00000, 0, 64'd0, 1'b1, 1'b0);
    check("illegal_err_clr", DW'(bus.err_grant), 64'd0);

    // Simultaneous pop of even and push to odd.
    step(1'b0, 5'b00001, 0, 64'd7, 1'b0, 1'b0);
    step(1'b1, 5'b10000, 4, 64'd9, 1'b1, 1'b0);
    check("simul_even", DW'(bus.count_even), 64'd0);
    check("simul_odd",  DW'(bus.count_odd),  64'd1);

    // Reset with both VCs occupied flushes everything.
    step(1'b0, 5'b00001, 0, 64'd21, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 0, 64'd0,  1'b0, 1'b1);
    step(1'b1, 5'b00000, 0, 64'd0,  1'b1, 1'b0);

    // Randomized traffic.
    pol = 1'b0;
    for (int n = 0; n < 600; n++) begin
      pol = ($urandom_range(0, 9) < 8) ? ~pol : 1'($urandom);
      ch  = $urandom_range(0, NIN - 1);
      case ($urandom_range(0, 5))
        0:       g = '0;
        1:       g = NIN'($urandom);
        default: g = NIN'(1) << ch;
      endcase
      step(pol, g, ch, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
